phys_reg_free_list: RTL
=======================

Name: phys_reg_free_list

Overview:
- Circular free list of physical register tags for a 4-wide rename stage.
- Hands out destination tags at rename and drives the clear-ready write port of the downstream ready-register table one cycle later.
- Accepts tags released at commit.
- On flush, rewinds the speculative head to the committed head, so every tag allocated but not committed is recovered.

Parameters:
- NUM_PHYS, 64, physical registers; also the list depth.
- TAG_W, 6, tag width, log2(NUM_PHYS).
- NUM_ARCH, 32, architectural registers; p0..p(NUM_ARCH-1) are mapped at reset.
- WIDTH, 4, allocate/free/commit lanes per cycle.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- allocEn  in  1  rename group valid this cycle.
- allocMask  in  [0:3]  lanes needing a destination tag.
- canAlloc  out  1  free entries >= popcount(allocMask).
- allocTag0..allocTag3  out  6 each  tag for lane i; combinational from specHead.
- freeEn  in  [0:3]  lanes releasing a tag at commit.
- freeTag0..freeTag3  in  6 each  released tags.
- commitAllocMask  in  [0:3]  committing lanes that own an allocated tag.
- flush  in  1  rewind the speculative head.
- clrEn  out  [0:3]  registered; feeds the ready table clear-enable.
- clrSel0..clrSel3  out  6 each  registered tag to mark not-ready.
- freeCount  out  7  tail - specHead.

Behaviour:
- Storage: mem[0:63] of 6 bits. Pointers specHead, commitHead and tail are 7 bits (6-bit index plus wrap bit). All arithmetic is mod 128; the index is ptr[5:0].
- Reset (asynchronous):
  - mem[i] = NUM_ARCH+i for i in 0..31; mem[32..63] = 0.
  - specHead = commitHead = 0; tail = 32.
  - clrEn = 0; clrSel* = 0; freeCount = 32.
  - Reset mid-operation discards all state and reloads these values.
- Allocation offset: off(i) = number of set allocMask bits in lanes 0..i-1.
- allocTag_i = mem[(specHead + off(i)) index]. Lanes with mask 0 drive the same value, which is don't-care.
- Accept = allocEn && canAlloc && !flush. On accept, specHead += popcount(allocMask). allocEn with mask 0000 is legal and advances by 0.
- Clear-ready output, latency 1 cycle: clrEn <= accept ? allocMask : 0 and clrSel_i <= allocTag_i.
  - clrEn has no zero-tag filtering; allocated tags are never 0.
- Free:
  - Lanes with freeEn[i]=1 and freeTag_i != 0 are packed in lane order.
  - They are written at tail, tail+1, …; tail += that count.
  - Tag 0 is dropped silently, matching the ready-table rule that p0 is never written.
- Commit: commitHead += popcount(commitAllocMask).
- Flush: specHead <= commitHead + popcount(commitAllocMask), so commit in the same cycle is honoured. No allocation is accepted in a flush cycle.
- Simultaneous alloc and free: both are applied. Tags freed this cycle become allocatable the next cycle; canAlloc uses the pre-update freeCount.
- Empty: freeCount = 0 → canAlloc = 0 for any nonzero mask. canAlloc = 1 for mask 0000.
- Full: tail - commitHead never exceeds NUM_PHYS - NUM_ARCH = 32. Exceeding it, or commitHead passing specHead, is an upstream protocol error. Assertions cover both; there is no RTL recovery.
- Wrap-around: index 63 → 0 is seamless for both reads and writes within one cycle.

Decomposition:
- Shared package (free-list constants reusable by the ready table):
  - NUM_PHYS, TAG_W, NUM_ARCH, WIDTH and PTR_W = TAG_W+1.
  - A tag typedef.
  - A popcount4 function.
  - A lane-prefix-offset function.
- One sub-module, free_list_pack4: compacts up to 4 valid free tags (nonzero, enabled) into consecutive write slots and returns the count.

Test Plan:
- Reset, then allocEn=1, mask=1111:
  - Expect allocTag0..3 = 32,33,34,35 and canAlloc=1.
  - Next cycle clrEn=1111, clrSel=32..35; freeCount = 28.
- Mask 1010 after reset: allocTag1=32, allocTag3=33, specHead += 2; next cycle clrEn=1010.
- Exhaust: 8 groups of 1111 leaves freeCount=0.
  - Mask 0001 → canAlloc=0 and no clrEn pulse.
  - freeEn=0001, freeTag0=5 → next cycle allocTag0=5.
- Free with zeros: freeEn=1111, tags {0,7,0,9} → tail += 2, and the list appends 7 then 9.
- Flush recovery:
  - Allocate 3 groups of 1111 (specHead=12) while commitAllocMask=1111 in one of those cycles (commitHead=4).
  - Then flush=1 with allocEn=1 → no accept, specHead=4.
  - Next allocTag0 = 36.
- Wrap: drive 60 alloc and matching frees with tags 40..63, then 1..36, and check the tag sequence read across index 63→0 is contiguous. Assert async reset mid-sequence → all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/phys_reg_free_list_pkg.sv
// Free-list constants, types and lane helpers shared with the ready table.
package phys_reg_free_list_pkg;

  localparam int unsigned NUM_PHYS = 64;
  localparam int unsigned TAG_W    = 6;
  localparam int unsigned NUM_ARCH = 32;
  localparam int unsigned WIDTH    = 4;
  localparam int unsigned PTR_W    = TAG_W + 1;
  localparam int unsigned CNT_W    = 3;

  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [0:WIDTH-1]   lane_mask_t;
  typedef logic [CNT_W-1:0]   lane_cnt_t;

  // Number of active lanes in a group.
  function automatic lane_cnt_t popcount4(input lane_mask_t m);
    lane_cnt_t c;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

  // Number of active lanes strictly below the given lane.
  function automatic lane_cnt_t lane_offset(input lane_mask_t m, input int unsigned lane);
    lane_cnt_t c;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < lane) begin
        c = c + CNT_W'(m[i]);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/free_list_pack4.sv
// Compacts enabled, nonzero released tags into consecutive write slots.
module free_list_pack4 import phys_reg_free_list_pkg::*; (
  input  logic [0:WIDTH-1]  en,
  input  logic [TAG_W-1:0]  tag_in [WIDTH],
  output logic [TAG_W-1:0]  slot   [WIDTH],
  output logic [CNT_W-1:0]  count
);

  // Lane-order packing; tag 0 is never returned to the list.
  always_comb begin
    slot  = '{default: '0};
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (en[i] && (tag_in[i] != '0)) begin
        slot[count[1:0]] = tag_in[i];
        count            = count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular physical-tag free list for a 4-wide rename stage with flush rewind.
module phys_reg_free_list import phys_reg_free_list_pkg::*; (
  input  logic               clk,
  input  logic               reset,
  input  logic               allocEn,
  input  logic [0:WIDTH-1]   allocMask,
  output logic               canAlloc,
  output logic [TAG_W-1:0]   allocTag0,
  output logic [TAG_W-1:0]   allocTag1,
  output logic [TAG_W-1:0]   allocTag2,
  output logic [TAG_W-1:0]   allocTag3,
  input  logic [0:WIDTH-1]   freeEn,
  input  logic [TAG_W-1:0]   freeTag0,
  input  logic [TAG_W-1:0]   freeTag1,
  input  logic [TAG_W-1:0]   freeTag2,
  input  logic [TAG_W-1:0]   freeTag3,
  input  logic [0:WIDTH-1]   commitAllocMask,
  input  logic               flush,
  output logic [0:WIDTH-1]   clrEn,
  output logic [TAG_W-1:0]   clrSel0,
  output logic [TAG_W-1:0]   clrSel1,
  output logic [TAG_W-1:0]   clrSel2,
  output logic [TAG_W-1:0]   clrSel3,
  output logic [PTR_W-1:0]   freeCount
);

  localparam ptr_t MAX_OUTSTANDING = PTR_W'(NUM_PHYS - NUM_ARCH);

  tag_t       mem_q [NUM_PHYS];
  tag_t       mem_d [NUM_PHYS];
  ptr_t       spec_head_q, spec_head_d;
  ptr_t       commit_head_q, commit_head_d;
  ptr_t       tail_q, tail_d;
  lane_mask_t clr_en_q, clr_en_d;
  tag_t       clr_sel_q [WIDTH];
  tag_t       clr_sel_d [WIDTH];

  tag_t       alloc_tag [WIDTH];
  tag_t       free_tag  [WIDTH];
  tag_t       pack_slot [WIDTH];
  lane_cnt_t  pack_cnt;
  lane_cnt_t  alloc_cnt;
  lane_cnt_t  commit_cnt;
  ptr_t       free_count;
  logic       accept;

  assign free_tag[0] = freeTag0;
  assign free_tag[1] = freeTag1;
  assign free_tag[2] = freeTag2;
  assign free_tag[3] = freeTag3;

  free_list_pack4 u_pack (
    .en     (freeEn),
    .tag_in (free_tag),
    .slot   (pack_slot),
    .count  (pack_cnt)
  );

  assign alloc_cnt  = popcount4(allocMask);
  assign commit_cnt = popcount4(commitAllocMask);
  assign free_count = tail_q - spec_head_q;
  assign canAlloc   = (PTR_W'(alloc_cnt) <= free_count);
  assign accept     = allocEn & canAlloc & ~flush;

  // Each lane reads the entry at specHead plus its prefix offset; index wraps mod 64.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      alloc_tag[i] = mem_q[TAG_W'(spec_head_q + PTR_W'(lane_offset(allocMask, i)))];
    end
  end

  // Pointer advance, release writes at tail, and clear-ready request capture.
  always_comb begin
    mem_d         = mem_q;
    commit_head_d = commit_head_q + PTR_W'(commit_cnt);
    spec_head_d   = spec_head_q;
    tail_d        = tail_q + PTR_W'(pack_cnt);
    clr_en_d      = '0;
    clr_sel_d     = alloc_tag;
    if (flush) begin
      spec_head_d = commit_head_d;
    end else if (accept) begin
      spec_head_d = spec_head_q + PTR_W'(alloc_cnt);
      clr_en_d    = allocMask;
    end
    for (int unsigned j = 0; j < WIDTH; j++) begin
      if (j < 32'(pack_cnt)) begin
        mem_d[TAG_W'(tail_q + PTR_W'(j))] = pack_slot[j];
      end
    end
  end

  // State registers; reset reloads the identity-mapped free tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PHYS; i++) begin
        mem_q[i] <= (i < NUM_ARCH) ? TAG_W'(NUM_ARCH + i) : '0;
      end
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= PTR_W'(NUM_ARCH);
      clr_en_q      <= '0;
      clr_sel_q     <= '{default: '0};
    end else begin
      mem_q         <= mem_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      clr_en_q      <= clr_en_d;
      clr_sel_q     <= clr_sel_d;
    end
  end

  assign allocTag0 = alloc_tag[0];
  assign allocTag1 = alloc_tag[1];
  assign allocTag2 = alloc_tag[2];
  assign allocTag3 = alloc_tag[3];
  assign clrEn     = clr_en_q;
  assign clrSel0   = clr_sel_q[0];
  assign clrSel1   = clr_sel_q[1];
  assign clrSel2   = clr_sel_q[2];
  assign clrSel3   = clr_sel_q[3];
  assign freeCount = free_count;

  // Upstream protocol: at most 32 tags outstanding past commit, and commit never overtakes rename.
  a_outstanding_bound: assert property (@(posedge clk) disable iff (reset)
    PTR_W'(tail_q - commit_head_q) <= MAX_OUTSTANDING);
  a_commit_order: assert property (@(posedge clk) disable iff (reset)
    PTR_W'(spec_head_q - commit_head_q) <= PTR_W'(tail_q - commit_head_q));

endmodule
